// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial transmit path.
//   tx_state_t : frame sequencer states
//   START_BIT, STOP_BIT, IDLE_LEVEL : serial line levels
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_bit_tick_counter.sv
// Bit-period timer for the serial transmitter.
//   CLK     : system clock
//   n_Reset : synchronous active-low reset
//   clear   : hold the count at zero (transmitter idle)
//   tick    : one-cycle pulse on the last cycle of each bit period
module bit_tick_counter
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic n_Reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!n_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With CLKS_PER_BIT=1 the count never leaves zero, so every active cycle ticks.
  assign tick = ~clear & (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter (start bit, data LSB first,
// stop bit), each bit held CLKS_PER_BIT clocks.
//   CLK     : system clock
//   n_Reset : synchronous active-low reset
//   DATA_IN : word to send, captured on VALID & READY
//   VALID   : producer offers a word
//   READY   : transmitter accepts a word this cycle (registered)
//   TX      : serial line, idles high (registered)
//   BUSY    : frame in progress (registered)
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                  CLK,
  input  logic                  n_Reset,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  VALID,
  output logic                  READY,
  output logic                  TX,
  output logic                  BUSY
);

  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_t             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [BW-1:0]         bit_cnt_q;
  logic                  tx_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  tick;
  logic                  tick_clear;

  // Timer is held at zero while idle so the start bit gets a full period
  // counted from the handshake edge.
  assign tick_clear = (state_q == IDLE);

  bit_tick_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .CLK    (CLK),
    .n_Reset(n_Reset),
    .clear  (tick_clear),
    .tick   (tick)
  );

  // Next bit to drive is bit 0 of the shifted word; avoids indexing
  // shift_q[1], which does not exist when DATA_WIDTH=1.
  always_comb begin
    shift_nxt = shift_q >> 1;
  end

  always_ff @(posedge CLK) begin
    if (!n_Reset) begin
      state_q   <= IDLE;
      tx_q      <= IDLE_LEVEL;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (VALID && ready_q) begin
            shift_q <= DATA_IN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            tx_q    <= START_BIT;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            shift_q   <= shift_nxt;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= STOP;
              tx_q    <= STOP_BIT;
            end else begin
              tx_q <= shift_nxt[0];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            tx_q    <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= IDLE_LEVEL;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign READY = ready_q;
  assign TX    = tx_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: a default 8-bit/4-clock instance and a
// 1-bit/1-clock instance, each compared every cycle against a waveform model
// that expands accepted words into queues of expected line levels.
module tb_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_a  = 1'b0;
  logic       valid_a = 1'b0;
  logic [7:0] data_a  = '0;
  logic       ready_a, tx_a, busy_a;

  logic       rstn_b  = 1'b0;
  logic       valid_b = 1'b0;
  logic [0:0] data_b  = '0;
  logic       ready_b, tx_b, busy_b;

  serial_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(4)
  ) dut_a (
    .CLK    (clk),
    .n_Reset(rstn_a),
    .DATA_IN(data_a),
    .VALID  (valid_a),
    .READY  (ready_a),
    .TX     (tx_a),
    .BUSY   (busy_a)
  );

  serial_tx #(
    .DATA_WIDTH  (1),
    .CLKS_PER_BIT(1)
  ) dut_b (
    .CLK    (clk),
    .n_Reset(rstn_b),
    .DATA_IN(data_b),
    .VALID  (valid_b),
    .READY  (ready_b),
    .TX     (tx_b),
    .BUSY   (busy_b)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state per instance: remaining line levels of the current frame.
  bit mq [2][$];
  bit e_tx   [2] = '{1'b1, 1'b1};
  bit e_rdy  [2] = '{1'b1, 1'b1};
  bit e_busy [2] = '{1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge of the model: a handshake appends the whole frame
  // (start, data LSB first, stop), each level repeated cpb times.
  task automatic model_edge(input int d, input bit rstn, input bit valid,
                            input int unsigned data, input int unsigned w,
                            input int unsigned cpb);
    bit lvl;
    if (!rstn) begin
      mq[d].delete();
      e_tx[d]   = 1'b1;
      e_rdy[d]  = 1'b1;
      e_busy[d] = 1'b0;
    end else begin
      if (valid && e_rdy[d]) begin
        for (int unsigned b = 0; b < w + 2; b++) begin
          if (b == 0)          lvl = 1'b0;
          else if (b == w + 1) lvl = 1'b1;
          else                 lvl = bit'((data >> (b - 1)) & 1);
          for (int unsigned c = 0; c < cpb; c++) mq[d].push_back(lvl);
        end
      end
      if (mq[d].size() > 0) begin
        e_tx[d]   = mq[d].pop_front();
        e_busy[d] = 1'b1;
        e_rdy[d]  = 1'b0;
      end else begin
        e_tx[d]   = 1'b1;
        e_busy[d] = 1'b0;
        e_rdy[d]  = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, rstn_a, valid_a, 32'(data_a), 8, 4);
    model_edge(1, rstn_b, valid_b, 32'(data_b), 1, 1);
    #1;
    chk("A_TX",    32'(tx_a),    32'(e_tx[0]));
    chk("A_READY", 32'(ready_a), 32'(e_rdy[0]));
    chk("A_BUSY",  32'(busy_a),  32'(e_busy[0]));
    chk("B_TX",    32'(tx_b),    32'(e_tx[1]));
    chk("B_READY", 32'(ready_b), 32'(e_rdy[1]));
    chk("B_BUSY",  32'(busy_b),  32'(e_busy[1]));
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset held with VALID asserted: nothing may start.
    #1;
    rstn_a = 1'b0; valid_a = 1'b1; data_a = 8'h55;
    rstn_b = 1'b0; valid_b = 1'b1; data_b = 1'b1;
    steps(2);
    valid_a = 1'b0; valid_b = 1'b0;
    rstn_a = 1'b1;  rstn_b = 1'b1;
    steps(2);

    // Single frame 0xA5 on A; minimal frame data=1 on B.
    valid_a = 1'b1; data_a = 8'hA5;
    valid_b = 1'b1; data_b = 1'b1;
    step();
    valid_a = 1'b0; data_a = 8'h00;
    valid_b = 1'b0; data_b = 1'b0;
    steps(44);

    // Word offered while busy, withdrawn before the frame ends.
    valid_a = 1'b1; data_a = 8'h96;
    step();
    valid_a = 1'b0;
    steps(10);
    valid_a = 1'b1; data_a = 8'h3C;
    steps(20);
    valid_a = 1'b0;
    steps(20);

    // Back-to-back with VALID held: 0xFF then 0x00.
    valid_a = 1'b1; data_a = 8'hFF;
    step();
    data_a = 8'h00;
    steps(84);
    valid_a = 1'b0;
    steps(5);

    // Reset during data bit 3 of 0x0F, then a clean frame.
    valid_a = 1'b1; data_a = 8'h0F;
    step();
    valid_a = 1'b0;
    steps(17);
    rstn_a = 1'b0;
    step();
    rstn_a = 1'b1;
    steps(2);
    valid_a = 1'b1; data_a = 8'h5A;
    step();
    valid_a = 1'b0;
    steps(44);

    // Randomized traffic on both instances, with occasional resets.
    for (int unsigned i = 0; i < 1500; i++) begin
      valid_a = ($urandom_range(0, 3) != 0);
      data_a  = 8'($urandom);
      rstn_a  = ($urandom_range(0, 299) != 0);
      valid_b = ($urandom_range(0, 2) != 0);
      data_b  = 1'($urandom);
      rstn_b  = ($urandom_range(0, 49) != 0);
      step();
    end
    rstn_a = 1'b1; rstn_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    steps(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
